vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths in pixels; H_TOTAL = sum = 800.
REQ-003 SHALL have parameter V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines; V_TOTAL = sum = 525.
REQ-004 SHALL have port Clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pixel_ce  output  1  pixel clock enable, high every second Clk cycle.
REQ-007 SHALL have port DrawX  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-008 SHALL have port DrawY  output  10  current vertical count, 0..V_TOTAL-1.
REQ-009 SHALL have port VGA_HS  output  1  horizontal sync, active low.
REQ-010 SHALL have port VGA_VS  output  1  vertical sync, active low.
REQ-011 SHALL have port VGA_BLANK_N  output  1  high only inside the visible region.
REQ-012 SHALL have port VGA_SYNC_N  output  1  tied 0.
REQ-013 SHALL have port line_start  output  1  one-Clk pulse at horizontal wrap.
REQ-014 SHALL have port frame_start  output  1  one-Clk pulse on entry to vertical blank.

Function
REQ-015 SHALL run on one clock, Clk; every register is updated only on its rising edge.
REQ-016 SHALL toggle pixel_ce each Clk cycle: 0 during Reset, 1 in the first cycle after Reset deasserts.
REQ-017 SHALL advance the counters only on Clk edges where pixel_ce=1; otherwise all outputs hold.
REQ-018 SHALL increment h_cnt each pixel; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
REQ-019 SHALL wrap v_cnt from V_TOTAL-1 to 0 on the same edge that h_cnt wraps from H_TOTAL-1 to 0.
REQ-020 SHALL drive DrawX=h_cnt and DrawY=v_cnt directly, including blanking values; there is no saturation.
REQ-021 SHALL make VGA_HS, VGA_VS and VGA_BLANK_N registered outputs, cycle-aligned with DrawX/DrawY: each reflects the counter values it is presented with, with zero relative skew.
REQ-022 SHALL drive VGA_HS=0 iff DrawX in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751].
REQ-023 SHALL drive VGA_VS=0 iff DrawY in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490,491].
REQ-024 SHALL drive VGA_BLANK_N=1 iff DrawX<640 and DrawY<480.
REQ-025 SHALL assert line_start for exactly one Clk, in the cycle DrawX first equals 0 after a wrap.
REQ-026 SHALL assert frame_start for exactly one Clk, in the cycle DrawY first equals V_VISIBLE (480) with DrawX=0.
REQ-027 SHALL give both line_start and frame_start in the cycle where DrawX=0 and DrawY=480.
REQ-028 SHALL use counter arithmetic of exactly 10 bits; it never reaches 1023 because of explicit compare-and-wrap.

Reset
REQ-029 SHALL, while Reset=1, force pixel_ce=0, DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, line_start=0 and frame_start=0.
REQ-030 SHALL, when Reset asserts mid-line or mid-frame, abandon the frame and return to the reset state on the next edge; no partial pulse follows.
REQ-031 SHALL, on the first pixel_ce=1 edge after release, present DrawX=0, DrawY=0, VGA_BLANK_N=1, line_start=0 and frame_start=0; no pulse is given for the initial position.

Verification
REQ-032 SHALL cover: Reset held 3 cycles, then released -> pixel_ce sequence 1,0,1,0; DrawX 0,0,1,1,2.
REQ-033 SHALL cover: one full line -> VGA_HS low for exactly 192 Clk cycles (DrawX 656..751); VGA_BLANK_N low for 320 Clk cycles per line in visible rows.
REQ-034 SHALL cover: full frame -> 800x525x2 = 840000 Clk cycles between successive frame_start pulses; VGA_VS low for 2 lines (3200 Clk cycles).
REQ-035 SHALL cover: wrap at (799,524) -> next pixel is (0,0) with line_start=1 and frame_start=0.
REQ-036 SHALL cover: Reset pulsed for 1 cycle at (700,490), while HS and VS are low -> next cycle DrawX=0, DrawY=0, HS=VS=1, with no line_start or frame_start.
REQ-037 SHALL cover: over 3 frames, line_start count = 1575 and frame_start count = 3; both pulses are one Clk wide.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock enable at half the system clock,
// horizontal/vertical counters, registered sync/blank decode and line/frame
// start pulses. All outputs change together, on the edge that raises pixel_ce.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // h_cnt/v_cnt hold the position to be presented on the next pixel edge;
  // the output registers load from them, so the first edge after reset
  // presents (0,0) and every output is decoded from the same position.
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       started;
  logic       tick;
  logic       hs_active;
  logic       vs_active;
  logic       visible;

  assign VGA_SYNC_N = 1'b0;

  // A pixel edge is the one on which pixel_ce rises.
  assign tick = ~pixel_ce;

  // Combinational decode of the position about to be presented.
  always_comb begin
    hs_active = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs_active = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  // Pixel clock enable: toggles every cycle, first high right after reset.
  always_ff @(posedge Clk) begin
    if (Reset) pixel_ce <= 1'b0;
    else       pixel_ce <= ~pixel_ce;
  end

  // Position counters with explicit compare-and-wrap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Registered outputs; pulses last one Clk since the following edge is never a pixel edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      started     <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        DrawX       <= h_cnt;
        DrawY       <= v_cnt;
        VGA_HS      <= ~hs_active;
        VGA_VS      <= ~vs_active;
        VGA_BLANK_N <= visible;
        line_start  <= started && (h_cnt == '0);
        frame_start <= started && (h_cnt == '0) && (v_cnt == V_VIS);
        started     <= 1'b1;
      end
    end
  end

endmodule
